// File: rtl/cpu_execute_md.sv
// Iterative multiply/divide execute unit for the RV M-extension (shift-add / restoring divide).
// Define CPU_EXECUTE_MD_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module cpu_execute_md #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [2:0]           i_op,
    input  logic [WIDTH-1:0]     i_rs1,
    input  logic [WIDTH-1:0]     i_rs2,
    input  logic [4:0]           i_inst_rd,
    output logic                 o_busy,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [4:0]           o_inst_rd,
    output logic [WIDTH-1:0]     o_rd
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned ProdW = 2 * WIDTH;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e r_state, w_state_next;

    logic [TAG_WIDTH-1:0] r_tag_lat, r_tag;
    logic [4:0]           r_rd_lat, r_inst_rd;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_opnd, r_rd;
    logic [ProdW-1:0]     r_prod;
    logic [CntW-1:0]      r_cnt;
    logic                 r_neg_a, r_neg_b, r_fast;

    logic             w_accept, w_fast, w_fast_div, w_div_zero, w_div_ovf;
    logic             w_sign_a, w_sign_b, w_div_ge;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_fast_val, w_quot, w_rem, w_result;
    logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
    logic [ProdW-1:0] w_mul_step, w_div_step, w_prod_signed;

    // Operand decode: signedness per funct3, magnitudes and the divide fast cases.
    always_comb begin
        w_sign_a   = i_rs1[WIDTH-1] & ((~i_op[2] & ~(i_op[1] & i_op[0])) | (i_op[2] & ~i_op[0]));
        w_sign_b   = i_rs2[WIDTH-1] & ((~i_op[2] & ~i_op[1]) | (i_op[2] & ~i_op[0]));
        w_mag_a    = w_sign_a ? -i_rs1 : i_rs1;
        w_mag_b    = w_sign_b ? -i_rs2 : i_rs2;
        w_div_zero = (i_rs2 == '0);
        w_div_ovf  = i_op[2] & ~i_op[0] & (i_rs1 == MinNeg) & (&i_rs2);
        w_fast_div = i_op[2] & (w_div_zero | w_div_ovf);
        // Overflow quotient is the most-negative dividend itself.
        if (i_op[1]) begin
            w_fast_val = w_div_zero ? i_rs1 : '0;
        end else begin
            w_fast_val = w_div_zero ? '1 : i_rs1;
        end
`ifdef CPU_EXECUTE_MD_FAST_MUL_EN
        w_fast = w_fast_div | ~i_op[2];
`else
        w_fast = w_fast_div;
`endif
        w_accept = (r_state == StIdle) & ~i_stall & (i_tag != r_tag);
    end

    always_comb begin
        w_mul_sum   = {1'b0, r_prod[ProdW-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
        w_mul_step  = {w_mul_sum, r_prod[WIDTH-1:1]};
        w_div_shift = {r_prod[ProdW-1:WIDTH], r_prod[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_div_ge    = ~w_div_diff[WIDTH];
        w_div_step  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                       r_prod[WIDTH-2:0], w_div_ge};
    end

    // Result sign fix-up at commit; r_prod holds {remainder, quotient} for divides.
    always_comb begin
        w_prod_signed = (r_neg_a ^ r_neg_b) ? -r_prod : r_prod;
        w_quot        = (r_neg_a ^ r_neg_b) ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
        w_rem         = r_neg_a ? -r_prod[ProdW-1:WIDTH] : r_prod[ProdW-1:WIDTH];
        if (r_fast) begin
            w_result = r_prod[WIDTH-1:0];
        end else if (r_op[2]) begin
            w_result = r_op[1] ? w_rem : w_quot;
        end else if (r_op[1:0] == 2'd0) begin
            w_result = w_prod_signed[WIDTH-1:0];
        end else begin
            w_result = w_prod_signed[ProdW-1:WIDTH];
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_fast) begin
                        w_state_next = StDone;
                    end else if (i_op[2]) begin
                        w_state_next = StDiv;
                    end else begin
                        w_state_next = StMul;
                    end
                end
            end
            StMul, StDiv: begin
                if (r_cnt == '0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (!i_stall) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tag_lat <= '0;
            r_tag     <= '0;
            r_rd_lat  <= '0;
            r_inst_rd <= '0;
            r_op      <= '0;
            r_opnd    <= '0;
            r_rd      <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_fast    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag_lat <= i_tag;
                r_rd_lat  <= i_inst_rd;
                r_op      <= i_op;
                r_neg_a   <= w_sign_a;
                r_neg_b   <= w_sign_b;
                r_cnt     <= CntLast;
                r_fast    <= w_fast_div;
                if (w_fast_div) begin
                    r_prod <= {{WIDTH{1'b0}}, w_fast_val};
`ifdef CPU_EXECUTE_MD_FAST_MUL_EN
                end else if (!i_op[2]) begin
                    r_prod <= ProdW'(w_mag_a) * ProdW'(w_mag_b);
`endif
                end else if (i_op[2]) begin
                    r_prod <= {{WIDTH{1'b0}}, w_mag_a};
                    r_opnd <= w_mag_b;
                end else begin
                    r_prod <= {{WIDTH{1'b0}}, w_mag_b};
                    r_opnd <= w_mag_a;
                end
            end
            if (r_state == StMul || r_state == StDiv) begin
                r_cnt  <= r_cnt - 1'b1;
                r_prod <= (r_state == StMul) ? w_mul_step : w_div_step;
            end
            if (r_state == StDone && !i_stall) begin
                r_tag     <= r_tag_lat;
                r_inst_rd <= r_rd_lat;
                r_rd      <= w_result;
            end
        end
    end

    assign o_busy    = (r_state != StIdle);
    assign o_tag     = r_tag;
    assign o_inst_rd = r_inst_rd;
    assign o_rd      = r_rd;

endmodule

// File: doc/cpu_execute_md.md
CPU_EXECUTE_MD -- requirements
Module: cpu_execute_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 SHALL have parameter TAG_WIDTH, default 8, width of the pipeline tag.
REQ-003 SHALL have port i_clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_stall  input  1  downstream stall; blocks acceptance and commit.
REQ-006 SHALL have port i_tag  input  TAG_WIDTH  upstream tag; differs from o_tag when a new operation is presented.
REQ-007 SHALL have port i_op  input  3  RV M-extension funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-008 SHALL have ports i_rs1, i_rs2  input  WIDTH  operands.
REQ-009 SHALL have port i_inst_rd  input  5  destination register index.
REQ-010 SHALL have port o_busy  output  1  operation in flight; upstream holds its inputs while high.
REQ-011 SHALL have port o_tag  output  TAG_WIDTH  tag of the last committed result.
REQ-012 SHALL have port o_inst_rd  output  5  destination index of the committed result.
REQ-013 SHALL have port o_rd  output  WIDTH  committed result.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, DONE; o_busy SHALL be high exactly when state != IDLE.
REQ-015 SHALL accept an operation at edge E0 when state=IDLE, i_stall=0 and i_tag != o_tag, latching tag, op, rd and operand magnitudes/signs.
REQ-016 SHALL go IDLE->MUL for ops 0-3 and IDLE->DIV for ops 4-7, unless the operation is a fast case (REQ-021, REQ-022), which SHALL go IDLE->DONE.
REQ-017 SHALL perform one shift-add (MUL) or one restoring shift-subtract (DIV) iteration per edge E1..E(WIDTH), then enter DONE.
REQ-018 SHALL, in DONE with i_stall=0, commit o_rd, o_inst_rd and o_tag on the same edge and return to IDLE; iterative latency is therefore WIDTH+1 edges after E0.
REQ-019 SHALL hold DONE and all outputs unchanged while i_stall=1, continuing iterations in MUL/DIV regardless of i_stall.
REQ-020 SHALL produce MUL as the low WIDTH bits and MULH/MULHSU/MULHU as the high WIDTH bits of the 2*WIDTH-bit product, using signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-021 SHALL treat divide by zero as a fast case: quotient all ones (DIV, DIVU), remainder = i_rs1 (REM, REMU).
REQ-022 SHALL treat signed overflow (most-negative / -1) as a fast case: DIV returns most-negative, REM returns 0.
REQ-023 SHALL compute signed DIV/REM on magnitudes and apply sign at commit: quotient negative iff operand signs differ, remainder takes the dividend's sign.
REQ-024 SHALL never accept a new operation in the same edge as a commit (one-cycle IDLE gap minimum).
REQ-025 SHALL compute and commit normally when i_inst_rd=0 (suppression is downstream's responsibility).

Reset
REQ-026 SHALL, on i_reset=1 at any edge including mid-operation, abort, enter IDLE and set o_tag=0, o_inst_rd=0, o_rd=0, o_busy=0.
REQ-027 SHALL accept the first operation no earlier than the first edge after i_reset deasserts.

Configuration
REQ-028 SHALL, with macro CPU_EXECUTE_MD_FAST_MUL_EN defined, compute all multiplies with a single-cycle 2*WIDTH product and treat ops 0-3 as fast cases (IDLE->DONE, commit at E1).
REQ-029 SHALL, without CPU_EXECUTE_MD_FAST_MUL_EN, use the iterative MUL state (REQ-017) and instantiate no full-width multiplier.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD (WIDTH=32) -> o_rd=0xFFFFFFEB, o_tag updates 33 edges after accept (1 edge with fast macro).
REQ-031 DIVU 100/7 -> o_rd=14; REMU 100/7 -> o_rd=2; o_busy high for 33 cycles each, one idle cycle between.
REQ-032 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; all commit at E1.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV -7/2 with i_stall=1 held from E10 to E40 -> iterations unaffected, commit on first edge with i_stall=0, o_rd=0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-035 i_reset pulsed at E15 of DIVU 1000/3 -> o_busy=0, o_tag=0, o_rd=0 next cycle; same op re-presented afterwards -> o_rd=333.
